// File: rtl/spi_pkg.sv
// Shared frame geometry, register map and FSM state type for the SPI register-write initiator.
package spi_pkg;

   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;
   localparam int RW_BIT  = 15;

   localparam logic [ADDR_W-1:0] REG_ID     = 7'h00;
   localparam logic [ADDR_W-1:0] REG_CTRL   = 7'h01;
   localparam logic [ADDR_W-1:0] REG_STATUS = 7'h02;
   localparam logic [ADDR_W-1:0] REG_CFG    = 7'h03;
   localparam logic [ADDR_W-1:0] REG_DATA   = 7'h04;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } spi_state_e;

   function automatic logic [FRAME_W-1:0] pack_frame(input logic              rw,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
      logic [FRAME_W-1:0] f;
      f                       = '0;
      f[RW_BIT]               = rw;
      f[RW_BIT-1 -: ADDR_W]   = addr;
      f[DATA_W-1:0]           = data;
      return f;
   endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Command port and SPI pins of spi_controller. SPI_CTRL_READBACK_EN adds cmd_rw, cipo and rd_data.
interface spi_controller_if;
   import spi_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic              sclk;
   logic              cs_n;
   logic              copi;
   logic              busy;
   logic              done;
`ifdef SPI_CTRL_READBACK_EN
   logic              cmd_rw;
   logic              cipo;
   logic [DATA_W-1:0] rd_data;

   modport master (output cmd_valid, cmd_addr, cmd_data, cmd_rw, cipo,
                   input  cmd_ready, sclk, cs_n, copi, busy, done, rd_data);
   modport slave  (input  cmd_valid, cmd_addr, cmd_data, cmd_rw, cipo,
                   output cmd_ready, sclk, cs_n, copi, busy, done, rd_data);
`else
   modport master (output cmd_valid, cmd_addr, cmd_data,
                   input  cmd_ready, sclk, cs_n, copi, busy, done);
   modport slave  (input  cmd_valid, cmd_addr, cmd_data,
                   output cmd_ready, sclk, cs_n, copi, busy, done);
`endif

endinterface

// File: rtl/spi_clk_gen.sv
// sclk half-period divider: counts 0..CLK_DIV-1 while enabled and flags the last count.
module spi_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == TC);

endmodule

// File: rtl/spi_controller.sv
// Mode-0 SPI initiator sending 16-bit {rw, addr, data} register writes.
// SPI_CTRL_READBACK_EN: cmd_rw drives the R/W bit and cipo is captured into rd_data.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for cmd_valid
// SETUP | cs_n low, first bit on copi, CS_SETUP cycles
// SHIFT | 16 sclk periods of 2*CLK_DIV cycles
// HOLD  | cs_n still low after last falling edge, CS_HOLD cycles
// GAP   | cs_n high minimum spacing, CS_HOLD cycles
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   spi_controller_if.slave bus
);

   localparam int TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int TW   = $clog2(TMAX + 1) + 1;

   spi_state_e         state_q, state_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [FRAME_W-1:0] shift_q, shift_d;
   logic [3:0]         bit_q, bit_d;
   logic               sclk_q, sclk_d;
   logic               cs_n_q, cs_n_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               tick;
   logic               accept;
   logic               rw_bit;

`ifdef SPI_CTRL_READBACK_EN
   assign rw_bit = bus.cmd_rw;
`else
   assign rw_bit = 1'b1;
`endif

   assign accept = bus.cmd_valid && (state_q == IDLE);

   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (state_q == SHIFT),
      .clr  (state_q != SHIFT),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      cs_n_d  = cs_n_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = pack_frame(rw_bit, bus.cmd_addr, bus.cmd_data);
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               bit_d   = '0;
               timer_d = TW'(CS_SETUP - 1);
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (timer_q == '0) state_d = SHIFT;
            else               timer_d = timer_q - 1'b1;
         end
         SHIFT: begin
            if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  bit_d  = bit_q + 4'd1;
               end else begin
                  // Every fall shifts, so after 16 falls copi is already 0 for HOLD.
                  sclk_d  = 1'b0;
                  shift_d = shift_q << 1;
                  // bit_q wraps to 0 on the 16th rising edge.
                  if (bit_q == 4'd0) begin
                     timer_d = TW'(CS_HOLD - 1);
                     state_d = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (timer_q == '0) begin
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
               timer_d = TW'(CS_HOLD - 1);
               state_d = GAP;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         GAP: begin
            if (timer_q == '0) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         shift_q <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         cs_n_q  <= cs_n_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef SPI_CTRL_READBACK_EN
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] rd_q, rd_d;

   // Data bits 7..0 occupy frame positions 8..15, i.e. bit_q[3] set at the rising tick.
   always_comb begin
      rx_d = rx_q;
      rd_d = rd_q;
      if (state_q == SHIFT && tick && !sclk_q && bit_q[3]) rx_d = {rx_q[DATA_W-2:0], bus.cipo};
      if (state_q == HOLD && timer_q == '0)                 rd_d = rx_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q <= '0;
         rd_q <= '0;
      end else begin
         rx_q <= rx_d;
         rd_q <= rd_d;
      end
   end

   assign bus.rd_data = rd_q;
`endif

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.sclk      = sclk_q;
   assign bus.cs_n      = cs_n_q;
   assign bus.copi      = shift_q[FRAME_W-1];
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: default, CLK_DIV=1 and CLK_DIV=7 instances sharing clk/rst_n.
module tb_spi_controller;
   import spi_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   spi_controller_if bus0 ();
   spi_controller_if bus1 ();
   spi_controller_if bus7 ();

   spi_controller #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus0));
   spi_controller #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) u_div1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));
   spi_controller #(.CLK_DIV(7), .CS_SETUP(2), .CS_HOLD(2)) u_div7 (
      .clk(clk), .rst_n(rst_n), .bus(bus7));

   // Peripheral-side capture per instance: frame bits on sclk rise, cleared on cs_n fall.
   logic [15:0] rx0 = '0, rx1 = '0, rx7 = '0;
   logic [15:0] last0 = '0, last1 = '0, last7 = '0;
   int          rises0 = 0, rises1 = 0, rises7 = 0;
   int          dones0 = 0, dones1 = 0, dones7 = 0;
   time         tr1_0 = 0, tr2_0 = 0, tr1_1 = 0, tr2_1 = 0, tr1_7 = 0, tr2_7 = 0;
   time         t_up0 = 0, gap0 = 0;

   always @(posedge bus0.sclk or negedge bus0.cs_n) begin
      if (bus0.sclk) begin
         rx0 = {rx0[14:0], bus0.copi};
         rises0++;
         if (rises0 == 1) tr1_0 = $time;
         if (rises0 == 2) tr2_0 = $time;
      end else begin
         rx0 = '0;
         rises0 = 0;
      end
   end
   always @(posedge bus1.sclk or negedge bus1.cs_n) begin
      if (bus1.sclk) begin
         rx1 = {rx1[14:0], bus1.copi};
         rises1++;
         if (rises1 == 1) tr1_1 = $time;
         if (rises1 == 2) tr2_1 = $time;
      end else begin
         rx1 = '0;
         rises1 = 0;
      end
   end
   always @(posedge bus7.sclk or negedge bus7.cs_n) begin
      if (bus7.sclk) begin
         rx7 = {rx7[14:0], bus7.copi};
         rises7++;
         if (rises7 == 1) tr1_7 = $time;
         if (rises7 == 2) tr2_7 = $time;
      end else begin
         rx7 = '0;
         rises7 = 0;
      end
   end

   always @(negedge clk) begin
      if (bus0.done === 1'b1) begin dones0++; last0 = rx0; end
      if (bus1.done === 1'b1) begin dones1++; last1 = rx1; end
      if (bus7.done === 1'b1) begin dones7++; last7 = rx7; end
   end

   always @(posedge bus0.cs_n or negedge bus0.cs_n) begin
      if (bus0.cs_n) t_up0 = $time;
      else           gap0  = $time - t_up0;
   end

`ifdef SPI_CTRL_READBACK_EN
   // Register model: shifts 0x3C out on falling edges so data bits land on rises 9..16.
   logic [7:0] rb_val = 8'h3C;
   logic       cipo_m = 1'b0;
   always @(negedge bus0.sclk) begin
      if (rises0 >= 8 && rises0 < 16) cipo_m = rb_val[15 - rises0];
      else                            cipo_m = 1'b0;
   end
   assign bus0.cipo = cipo_m;
   assign bus1.cipo = 1'b0;
   assign bus7.cipo = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic ready_of(input int idx);
      case (idx)
         0:       return bus0.cmd_ready;
         1:       return bus1.cmd_ready;
         default: return bus7.cmd_ready;
      endcase
   endfunction

   function automatic int dones_of(input int idx);
      case (idx)
         0:       return dones0;
         1:       return dones1;
         default: return dones7;
      endcase
   endfunction

   task automatic wait_ready(input int idx, output int n);
      n = 0;
      while (!ready_of(idx) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_wait", 32'(n < 1000), 32'd1);
   endtask

   task automatic wait_done(input int idx, input int target);
      int n;
      n = 0;
      while (dones_of(idx) < target && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_wait", 32'(n < 2000), 32'd1);
   endtask

   task automatic send(input int idx, input logic [6:0] a, input logic [7:0] d);
      int n;
      wait_ready(idx, n);
      case (idx)
         0:       begin bus0.cmd_addr = a; bus0.cmd_data = d; bus0.cmd_valid = 1'b1; end
         1:       begin bus1.cmd_addr = a; bus1.cmd_data = d; bus1.cmd_valid = 1'b1; end
         default: begin bus7.cmd_addr = a; bus7.cmd_data = d; bus7.cmd_valid = 1'b1; end
      endcase
      @(posedge clk); #1;
      bus0.cmd_valid = 1'b0;
      bus1.cmd_valid = 1'b0;
      bus7.cmd_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int d0;
      logic [15:0] f1;

      bus0.cmd_valid = 1'b0; bus0.cmd_addr = '0; bus0.cmd_data = '0;
      bus1.cmd_valid = 1'b0; bus1.cmd_addr = '0; bus1.cmd_data = '0;
      bus7.cmd_valid = 1'b0; bus7.cmd_addr = '0; bus7.cmd_data = '0;
`ifdef SPI_CTRL_READBACK_EN
      bus0.cmd_rw = 1'b1; bus1.cmd_rw = 1'b1; bus7.cmd_rw = 1'b1;
`endif

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n", bus0.cs_n, 1'b1);
      check("rst_sclk", bus0.sclk, 1'b0);
      check("rst_copi", bus0.copi, 1'b0);
      check("rst_busy", bus0.busy, 1'b0);
      check("rst_done", bus0.done, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", bus0.cmd_ready, 1'b1);

      // Single write 0x02/0xA5
      d0 = dones0;
      send(0, REG_STATUS, 8'hA5);
      check("acc_busy", bus0.busy, 1'b1);
      check("acc_ready", bus0.cmd_ready, 1'b0);
      check("acc_cs_n", bus0.cs_n, 1'b0);
      check("acc_copi", bus0.copi, 1'b1);
      wait_ready(0, n);
      check("frame_len", 32'(n + 1), 32'd135);
      check("frame_a5", last0, 16'h82A5);
      check("rises_a5", 32'(rises0), 32'd16);
      check("done_once", 32'(dones0 - d0), 32'd1);
      check("period_div4", 32'((tr2_0 - tr1_0) / 10), 32'd8);

      // Back-to-back with cmd_valid held
      d0 = dones0;
      bus0.cmd_addr = REG_ID; bus0.cmd_data = 8'h11; bus0.cmd_valid = 1'b1;
      wait_done(0, d0 + 1);
      f1 = last0;
      bus0.cmd_addr = REG_DATA; bus0.cmd_data = 8'hFF;
      wait_ready(0, n);
      @(posedge clk); #1;
      bus0.cmd_valid = 1'b0;
      wait_done(0, d0 + 2);
      check("b2b_frame1", f1, 16'h8011);
      check("b2b_frame2", last0, 16'h84FF);
      check("b2b_gap", 32'(gap0), 32'd30);

      // Request during SHIFT is ignored, frame in flight unchanged
      d0 = dones0;
      send(0, REG_CTRL, 8'h3C);
      repeat (40) @(posedge clk);
      #1;
      bus0.cmd_addr = 7'h7F; bus0.cmd_data = 8'h00; bus0.cmd_valid = 1'b1;
      @(posedge clk); #1;
      check("shift_ready", bus0.cmd_ready, 1'b0);
      check("shift_busy", bus0.busy, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      bus0.cmd_valid = 1'b0;
      wait_done(0, d0 + 1);
      check("inflight_frame", last0, 16'h813C);
      wait_ready(0, n);
      repeat (5) @(posedge clk);
      #1;
      check("no_extra_cs", bus0.cs_n, 1'b1);
      check("no_extra_done", 32'(dones0 - d0), 32'd1);

      // Reset at the 7th sclk rising edge
      send(0, REG_CFG, 8'hC3);
      n = 0;
      while (rises0 < 7 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("edge7_reached", 32'(rises0), 32'd7);
      d0 = dones0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_sclk", bus0.sclk, 1'b0);
      check("mid_rst_cs_n", bus0.cs_n, 1'b1);
      check("mid_rst_busy", bus0.busy, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("mid_rst_nodone", 32'(dones0 - d0), 32'd0);
      check("mid_rst_ready", bus0.cmd_ready, 1'b1);
      send(0, REG_CFG, 8'h5A);
      wait_done(0, d0 + 1);
      check("post_rst_frame", last0, 16'h835A);
      check("post_rst_rises", 32'(rises0), 32'd16);

      // CLK_DIV = 1
      d0 = dones1;
      send(1, REG_DATA, 8'h96);
      wait_ready(1, n);
      check("div1_len", 32'(n + 1), 32'd39);
      check("div1_frame", last1, 16'h8496);
      check("div1_period", 32'((tr2_1 - tr1_1) / 10), 32'd2);
      check("div1_done", 32'(dones1 - d0), 32'd1);

      // CLK_DIV = 7
      d0 = dones7;
      send(2, REG_STATUS, 8'h0F);
      wait_ready(2, n);
      check("div7_len", 32'(n + 1), 32'd231);
      check("div7_frame", last7, 16'h820F);
      check("div7_period", 32'((tr2_7 - tr1_7) / 10), 32'd14);
      check("div7_rises", 32'(rises7), 32'd16);

`ifdef SPI_CTRL_READBACK_EN
      // Read of REG_STATUS with the model returning 0x3C
      d0 = dones0;
      bus0.cmd_rw = 1'b0;
      send(0, REG_STATUS, 8'h00);
      wait_done(0, d0 + 1);
      bus0.cmd_rw = 1'b1;
      check("rd_rw_bit", last0[15], 1'b0);
      check("rd_frame", last0, 16'h0200);
      check("rd_data", bus0.rd_data, 8'h3C);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
